// File: rtl/dlfloat16_pkg.sv
// -----------------------------------------------------------------------------
// dlfloat16_pkg
// Shared DLFloat16 format constants and the unpacked-operand helper. Both the
// unpack unit and the downstream rounder import this package, so the unpacked
// layout {sign, exp, hidden, frac, grs} is defined here exactly once.
// -----------------------------------------------------------------------------
package dlfloat16_pkg;

    localparam int EXP_W  = 6;
    localparam int FRAC_W = 9;
    localparam int BIAS   = 31;
    localparam int GRS_W  = 3;

    // Packed operand width: sign + exponent + fraction.
    localparam int OP_W   = 1 + EXP_W + FRAC_W;
    // Unpacked operand width: sign + exponent + hidden + fraction + grs (= 20).
    localparam int UNP_W  = 1 + EXP_W + 1 + FRAC_W + GRS_W;

    // Magnitude field of the single NaN/infinity encoding (exp and frac all ones).
    localparam logic [EXP_W+FRAC_W-1:0] NANINF_MAG = 15'h7FFF;
    // Masks the sign off a packed operand.
    localparam logic [OP_W-1:0]         MAG_MASK   = 16'h7FFF;

    // Builds the rounder input format. Exponent stays biased; grs starts cleared.
    function automatic logic [UNP_W-1:0] unpack_fmt(input logic [OP_W-1:0] op,
                                                    input logic            hidden);
        return {op[OP_W-1:FRAC_W], hidden, op[FRAC_W-1:0], {GRS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dlfloat16_classify.sv
// -----------------------------------------------------------------------------
// dlfloat16_classify
// Purely combinational operand classifier.
//   op        in   packed DLFloat16 operand {sign, exp, frac}
//   is_zero   out  magnitude is zero (+/-0)
//   is_naninf out  magnitude is the NaN/infinity encoding
//   hidden    out  implicit leading one; every non-zero encoding is normal
// -----------------------------------------------------------------------------
module dlfloat16_classify
    import dlfloat16_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            is_zero,
    output logic            is_naninf,
    output logic            hidden
);

    // Sign is masked rather than sliced off so the whole operand feeds the compare.
    logic [OP_W-1:0] mag;

    assign mag       = op & MAG_MASK;
    assign is_zero   = (mag == '0);
    assign is_naninf = (mag == {1'b0, NANINF_MAG});
    // No subnormals in this format: exp == 0 with a non-zero fraction is normal.
    assign hidden    = !is_zero;

endmodule

// File: rtl/dlfloat16_unpack_unit.sv
// -----------------------------------------------------------------------------
// dlfloat16_unpack_unit
// Two-stage valid/ready pipeline that classifies a DLFloat16 operand and
// expands it into the rounder input format.
//   clk, rst    clock; asynchronous active-high reset
//   in_valid    in_data valid          in_ready   unit accepts in_data
//   in_data     {sign, exp, frac}
//   out_valid   out_* valid            out_ready  consumer accepts out_*
//   out_data    {sign, exp, hidden, frac, grs}
//   out_zero    operand is +/-0        out_naninf operand is NaN/infinity
//   occupancy   operands held in the pipeline (0..2)
//   accept_cnt  free-running count of accepted operands (wraps)
// S1 holds the raw operand plus its classification; S2 is the output register.
// -----------------------------------------------------------------------------
module dlfloat16_unpack_unit
    import dlfloat16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [UNP_W-1:0]  out_data,
    output logic              out_zero,
    output logic              out_naninf,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  accept_cnt
);

    logic            cls_zero;
    logic            cls_naninf;
    logic            cls_hidden;

    logic            s1_valid;
    logic [OP_W-1:0] s1_data;
    logic            s1_zero;
    logic            s1_naninf;
    logic            s1_hidden;

    logic            s2_load;
    logic            s1_load;
    logic            in_fire;

    dlfloat16_classify u_classify (
        .op        (in_data),
        .is_zero   (cls_zero),
        .is_naninf (cls_naninf),
        .hidden    (cls_hidden)
    );

    // S2 (the output register) is free when empty or being drained this cycle.
    assign s2_load  = !out_valid || out_ready;
    // S1 is free when empty or handing its operand to S2 this cycle.
    assign s1_load  = !s1_valid || s2_load;
    // Depends only on state, out_ready and rst, never on in_valid.
    assign in_ready = !rst && s1_load;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_zero   <= 1'b0;
            s1_naninf <= 1'b0;
            s1_hidden <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= in_data;
                s1_zero   <= cls_zero;
                s1_naninf <= cls_naninf;
                s1_hidden <= cls_hidden;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_naninf <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            // Payload is left untouched when S1 is empty; out_valid alone marks it stale.
            if (s1_valid) begin
                out_data   <= unpack_fmt(s1_data, s1_hidden);
                out_zero   <= s1_zero;
                out_naninf <= s1_naninf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_cnt <= '0;
        end else if (in_fire) begin
            accept_cnt <= accept_cnt + 1'b1;
        end
    end

    assign occupancy = {1'b0, s1_valid} + {1'b0, out_valid};

endmodule

// File: doc/dlfloat16_unpack_unit.md
DLFLOAT16_UNPACK_UNIT -- requirements
Module: dlfloat16_unpack_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of accepted-operand counter.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  in_data valid.
REQ-005 in_ready  output  1  unit accepts in_data this cycle.
REQ-006 in_data  input  16  DLFloat16 operand {sign, exp[5:0], frac[8:0]}.
REQ-007 out_valid  output  1  out_* valid.
REQ-008 out_ready  input  1  consumer accepts out_* this cycle.
REQ-009 out_data  output  20  unpacked operand {sign, exp[5:0], hidden, frac[8:0], grs[2:0]}, the rounder input format.
REQ-010 out_zero  output  1  operand is +/-0.
REQ-011 out_naninf  output  1  operand is the NaN/infinity encoding.
REQ-012 occupancy  output  2  operands held in pipeline, 0..2.
REQ-013 accept_cnt  output  CNT_W  count of accepted operands.

Function
REQ-014 Transfer occurs on a port only in a cycle with valid and ready both high at the rising edge.
REQ-015 Two register stages S1, S2; each has a valid bit; latency in_data accept to out_valid = 2 cycles when unstalled.
REQ-016 Throughput one operand per cycle while out_ready is high.
REQ-017 S2 loads when S2 empty or out_ready high; S1 loads when S1 empty or S1 moves to S2 that cycle.
REQ-018 in_ready = !S1_valid or S1 advances; in_ready combinational from out_ready only, never from in_valid.
REQ-019 out_* stable and out_valid held high while out_valid and !out_ready.
REQ-020 S1 captures in_data and classification; S2 holds formatted out_data and flags.
REQ-021 Zero: in_data[14:0]==0; hidden=0, flags out_zero=1, sign preserved.
REQ-022 NaN/inf: in_data[14:0] all ones; hidden=1, out_naninf=1, sign preserved.
REQ-023 All other encodings normal (no subnormals, exp=0 normal); hidden=1, both flags 0.
REQ-024 exp and frac copied unchanged (bias 31 retained); grs always 3'b000.
REQ-025 occupancy = S1_valid + S2_valid; simultaneous accept and output leaves it unchanged.
REQ-026 accept_cnt increments by 1 per input transfer, wraps 2^CNT_W-1 -> 0.
REQ-027 Operand order strictly preserved; no drop, no duplication under any out_ready pattern.

Reset
REQ-028 rst high clears S1_valid, S2_valid, occupancy, accept_cnt immediately, independent of clk.
REQ-029 During reset: out_valid=0, in_ready=0, out_data=20'h0, out_zero=0, out_naninf=0.
REQ-030 Operands in flight at reset discarded; first cycle after deassertion in_ready=1.

Structure
REQ-031 Package dlfloat16_pkg holds EXP_W=6, FRAC_W=9, BIAS=31, GRS_W=3, UNP_W=20, NANINF_MAG=15'h7FFF, shared with the rounder.
REQ-032 One combinational sub-module dlfloat16_classify (in: 16-bit operand; out: is_zero, is_naninf, hidden) instanced before S1.

Verification
REQ-033 in_data=16'h5DFF, out_ready=1 -> 2 cycles later out_data=20'h5DFF8, flags 0.
REQ-034 in_data=16'h8000 -> out_data=20'h80000, out_zero=1; 16'h7FFF -> out_data=20'h7FFF8, out_naninf=1; 16'hBE00 -> 20'hBF000.
REQ-035 out_ready=0, present 3 operands back-to-back -> 2 accepted, in_ready=0, occupancy=2; release out_ready -> all 3 emerge in order, one per cycle.
REQ-036 rst pulsed asynchronously with occupancy=2 -> out_valid=0, occupancy=0, accept_cnt=0 same instant; no stale operand emitted after release.
REQ-037 CNT_W=4, stream 17 operands -> accept_cnt wraps 15 -> 0, reads 1 at end.
REQ-038 Random in_valid/out_ready, 1000 operands -> output sequence equals scoreboard model, out_* stable during stalls.
